mul_div_unit: RTL and testbench



---
 rtl/rv32_pkg.sv | 25 ++
 rtl/mul_div_unit.sv | 154 +++++++++++++++
 tb/tb_mul_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: register widths, RV32M funct3 encodings and the
// state type of the iterative multiply/divide unit.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M unit: 32-step shift-add multiply / restoring divide on
// operand magnitudes, with sign fix-up folded into the last step.
module mul_div_unit
  import rv32_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out,
  output muldiv_state_t         state_dbg
);

  localparam int W2 = 2 * XLEN;

  // Handshake: a request is taken on a rising edge where start=1, kill=0 and
  // the unit is not in CALC; done pulses for one cycle with result/rd_out.
  muldiv_state_t         state_q;
  logic [4:0]            cnt_q;
  muldiv_op_t            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  neg_q;
  logic [W2-1:0]         acc_q;
  logic [XLEN-1:0]       b_q;
  logic                  busy_q;
  logic                  done_q;
  logic [XLEN-1:0]       result_q;
  logic [REG_ADDR_W-1:0] rd_out_q;

  muldiv_op_t      op_in;
  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg, sign_in, is_special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    op_in       = muldiv_op_t'(op);
    accept      = start && !kill && (state_q != ST_CALC);
    a_signed    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg       = a_signed & src_a[XLEN-1];
    b_neg       = b_signed & src_b[XLEN-1];
    a_mag       = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag       = b_neg ? (~src_b + 1'b1) : src_b;
    // Remainder takes the dividend's sign; product and quotient the XOR.
    sign_in     = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
    is_special  = 1'b0;
    special_res = '0;
    if (op_in[2]) begin
      if (src_b == '0) begin
        is_special  = 1'b1;
        special_res = op_in[1] ? src_a : '1;
      end else if (!op_in[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1)) begin
        is_special  = 1'b1;
        special_res = op_in[1] ? '0 : src_a;
      end
    end
  end

  logic [XLEN:0]   mul_sum, div_rem, div_diff;
  logic [W2-1:0]   mul_next, div_next, step_next, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    // Upper half holds the partial remainder, lower half shifts in quotient bits.
    div_rem   = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_rem - {1'b0, b_q};
    div_next  = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
    prod_fix  = neg_q ? (~step_next + 1'b1) : step_next;
    quo_fix   = neg_q ? (~step_next[XLEN-1:0] + 1'b1) : step_next[XLEN-1:0];
    rem_fix   = neg_q ? (~step_next[W2-1:XLEN] + 1'b1) : step_next[W2-1:XLEN];
    case (op_q)
      OP_MUL:                        final_res = step_next[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[W2-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo_fix;
      default:                       final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_CALC: begin
          if (kill) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= step_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == 5'd31) begin
              state_q  <= ST_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= final_res;
              rd_out_q <= rd_q;
            end
          end
        end
        default: begin
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= rd_in;
            neg_q <= sign_in;
            acc_q <= {{XLEN{1'b0}}, a_mag};
            b_q   <= b_mag;
            cnt_q <= '0;
            if (is_special) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
              rd_out_q <= rd_in;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign rd_out    = rd_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases plus random
// operations checked against an arithmetic reference model.
module tb_mul_div_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  muldiv_state_t state_dbg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [31:0] last_result = '0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .rd_in(rd_in), .kill(kill), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = 0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [31:0] exp, input bit push);
    start = 1'b1; op = o; src_a = a; src_b = b; rd_in = rd;
    if (push) begin
      exp_q.push_back(exp);
      exp_rd_q.push_back(rd);
    end
  endtask

  task automatic release_inputs();
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    src_a = $urandom; src_b = $urandom;
    rd_in = 5'($urandom_range(0, 31));
  endtask

  // Entered at the first falling edge after the accept edge; returns at the
  // falling edge where done is seen (or when the budget runs out).
  task automatic wait_done(input int exp_lat, input bit poke, input string tag);
    int edges = 0;
    bit busy_bad = 1'b0;
    logic [31:0] e;
    logic [4:0]  er;
    while (!done && edges < 40) begin
      if (exp_lat > 0 && !busy) busy_bad = 1'b1;
      @(negedge clk);
      edges++;
      if (poke && edges == 5) begin
        start = 1'b1; op = 3'd5; src_a = 32'd50; src_b = 32'd5; rd_in = 5'd31;
      end
      if (poke && edges == 6) start = 1'b0;
    end
    check({tag, "_lat"}, edges, exp_lat);
    check({tag, "_busy"}, busy_bad, 0);
    e  = exp_q.pop_front();
    er = exp_rd_q.pop_front();
    check({tag, "_res"}, result, e);
    check({tag, "_rd"}, rd_out, er);
    last_result = e;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit poke, input string tag);
    @(negedge clk);
    drive_start(o, a, b, rd, exp, 1'b1);
    @(negedge clk);
    release_inputs();
    wait_done(lat, poke, tag);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    bit saw_done;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_rd", rd_out, 0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 32, 1'b1, "mul");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 32, 1'b0, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 32, 1'b0, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 32, 1'b0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 32, 1'b0, "div_neg");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 32, 1'b0, "rem_neg");
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 32, 1'b0, "divu");
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 32, 1'b0, "remu");
    run_op(3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, 1'b0, "div0");
    run_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 0, 1'b0, "rem0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0, 1'b0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0, 1'b0, "rem_ovf");
    run_op(3'd0, 32'd9, 32'd9, 5'd0, 32'd81, 32, 1'b0, "mul_x0");

    // Back-to-back: second start issued in the DONE cycle of the first.
    @(negedge clk);
    drive_start(3'd0, 32'd3, 32'd4, 5'd13, 32'd12, 1'b1);
    @(negedge clk);
    release_inputs();
    wait_done(32, 1'b0, "b2b_first");
    drive_start(3'd5, 32'd9, 32'd3, 5'd14, 32'd3, 1'b1);
    @(negedge clk);
    release_inputs();
    check("b2b_gap_done", done, 0);
    check("b2b_gap_busy", busy, 1);
    wait_done(32, 1'b0, "b2b_second");

    // Reset mid-calculation at counter 10.
    @(negedge clk);
    drive_start(3'd5, 32'd1000, 32'd7, 5'd15, 32'd0, 1'b0);
    @(negedge clk);
    release_inputs();
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_rst_busy", busy, 0);
    check("abort_rst_done", done, 0);
    check("abort_rst_result", result, 0);
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
    check("abort_rst_nodone", saw_done, 0);

    // Kill at counter 20 keeps the previous result.
    run_op(3'd0, 32'd6, 32'd7, 5'd16, 32'd42, 32, 1'b0, "pre_kill");
    @(negedge clk);
    drive_start(3'd4, 32'd77, 32'd5, 5'd17, 32'd0, 1'b0);
    @(negedge clk);
    release_inputs();
    repeat (20) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_state", state_dbg, ST_IDLE);
    saw_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
    check("kill_nodone", saw_done, 0);
    check("kill_result_kept", result, last_result);

    // kill together with start in IDLE: nothing is accepted.
    @(negedge clk);
    drive_start(3'd4, 32'd5, 32'd0, 5'd18, 32'd0, 1'b0);
    kill = 1'b1;
    @(negedge clk);
    release_inputs();
    kill = 1'b0;
    check("kill_start_busy", busy, 0);
    check("kill_start_done", done, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(ro, ra, rb, 5'($urandom_range(0, 31)), ref_res(ro, ra, rb),
             is_special(ro, ra, rb) ? 0 : 32, 1'b0, $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
